qpu_dmem_icb_responder: RTL
===========================

# qpu_dmem_icb_responder

Single-port ICB target serving the LSU's load/store command channel from an internal word-addressed data scratchpad. It accepts one command at a time, performs masked writes or one-cycle-latency reads, and returns a response beat (read data plus error flag) to the load write-back path. It is the responder end of the LSU ICB interface and sits between the LSU and the QPU data memory space.

## Interface
- `XLEN`, 32, data width; fixed at 32, so the mask is 4 bits.
- `ADDR_SIZE`, 32, command address width.
- `DEPTH`, 256, number of 32-bit words in the scratchpad; must be a power of 2.
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0; must be aligned to 4*DEPTH.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `icb_cmd_valid`  in  1  command valid.
- `icb_cmd_ready`  out  1  command ready.
- `icb_cmd_addr`  in  ADDR_SIZE  byte address.
- `icb_cmd_read`  in  1  1 = load, 0 = store.
- `icb_cmd_wdata`  in  XLEN  store data.
- `icb_cmd_wmask`  in  XLEN/8  byte-enable for stores; bit i covers byte i.
- `icb_rsp_valid`  out  1  response valid.
- `icb_rsp_ready`  in  1  response ready.
- `icb_rsp_rdata`  out  XLEN  load data; 0 for stores and errors.
- `icb_rsp_err`  out  1  out-of-range or misaligned access.
- `busy`  out  1  a response is pending.

## Operation
- Two-state FSM:
  - IDLE: no pending response.
  - RSP: response held on the rsp channel.
- Command handshake (`cmd_hsk`) = `icb_cmd_valid & icb_cmd_ready`.
- Response handshake (`rsp_hsk`) = `icb_rsp_valid & icb_rsp_ready`.
- `icb_cmd_ready` = !rst & (state==IDLE | rsp_hsk), so a back-to-back command is accepted in the same cycle the previous response drains.
- Address decode:
  - offset = addr - BASE_ADDR.
  - in_range = addr >= BASE_ADDR and offset < 4*DEPTH.
  - aligned = addr[1:0]==0.
  - index = offset[log2(DEPTH)+1:2].
  - err = !in_range | !aligned.
- Store with no error, on cmd_hsk: for each i with wmask[i]=1, mem[index][8i+7:8i] <= wdata[8i+7:8i]. All other bytes are unchanged.
- Store with wmask=0 is legal. It writes nothing and gets a response with err=0.
- Erroring store: memory is unchanged and the response has err=1.
- Load with no error, on cmd_hsk: rdata register <= mem[index], the value before any write in the same cycle.
- Erroring load: rdata register <= 0 and err=1.
- Transitions:
  - IDLE --cmd_hsk--> RSP.
  - RSP --rsp_hsk & !cmd_hsk--> IDLE.
  - RSP --rsp_hsk & cmd_hsk--> RSP, loaded with the new beat.
  - RSP with !rsp_ready: stays in RSP; rdata and err hold stable.
- `icb_rsp_valid` = (state==RSP). `busy` = (state==RSP).
- Memory contents are not reset. Only the control state and the response registers are reset.

## Timing
- Reset values: state=IDLE, icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0, busy=0, icb_cmd_ready=0 while rst=1. icb_cmd_ready=1 in the first cycle after rst falls.
- Latency: cmd_hsk in cycle N gives icb_rsp_valid=1 in cycle N+1, for both loads and stores.
- Store data is visible to a load accepted in cycle N+1 or later.
- Throughput: one command per cycle when icb_rsp_ready is held high.
- Backpressure: while the response is stalled, icb_cmd_ready=0. A command presented then stays unaccepted; the master holds valid and the payload.
- Reset asserted mid-transaction: the pending response is dropped (rsp_valid=0 next cycle). A store that completed its cmd_hsk before reset stays written.
- Inputs are sampled only on cmd_hsk. The payload is ignored when valid=0.
- Address arithmetic is unsigned ADDR_SIZE-bit. An addr below BASE_ADDR wraps to a huge offset and is therefore out of range.

## Test plan
- Reset, then store addr=BASE+0x10, wdata=0xDEADBEEF, wmask=4'b1111, then load the same address -> rsp_valid one cycle after each cmd_hsk; the load gives rdata=0xDEADBEEF, err=0; the store rsp gives rdata=0.
- Store 0x11223344 with mask 1111 to BASE+0x20, then store 0xAABBCCDD with mask 0101, then load -> rdata=0x11BB33DD.
- Load at BASE+4*DEPTH, load at BASE+0x2, and store at BASE+0x4 with an addr[1:0]=2'b01 variant -> err=1 and rdata=0 for each; the word at BASE+0x4 is unchanged on a follow-up load.
- Hold rsp_ready=0 for 3 cycles after a load while cmd_valid is asserted with a second command -> cmd_ready=0, and rsp rdata/err stay stable for all 3 cycles. When rsp_ready rises, the second command is accepted in that same cycle and its rsp appears the next cycle.
- Stream 8 alternating store/load commands to distinct addresses with rsp_ready=1 -> one cmd_hsk per cycle and 8 responses in order, each load returning its paired store's data.
- Assert rst for one cycle while in RSP -> rsp_valid=0, busy=0, rdata=0 the next cycle; cmd_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/qpu_dmem_icb_responder.sv
// rtl/qpu_dmem_icb_responder.sv - ICB responder backed by a word-addressed data scratchpad
module qpu_dmem_icb_responder #(
  parameter int unsigned          XLEN      = 32,
  parameter int unsigned          ADDR_SIZE = 32,
  parameter int unsigned          DEPTH     = 256,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 icb_cmd_valid,
  output logic                 icb_cmd_ready,
  input  logic [ADDR_SIZE-1:0] icb_cmd_addr,
  input  logic                 icb_cmd_read,
  input  logic [XLEN-1:0]      icb_cmd_wdata,
  input  logic [XLEN/8-1:0]    icb_cmd_wmask,
  output logic                 icb_rsp_valid,
  input  logic                 icb_rsp_ready,
  output logic [XLEN-1:0]      icb_rsp_rdata,
  output logic                 icb_rsp_err,
  output logic                 busy
);

  localparam int unsigned          IDX_W = $clog2(DEPTH);
  localparam int unsigned          NBYTE = XLEN / 8;
  localparam logic [ADDR_SIZE-1:0] SPAN  = ADDR_SIZE'(4 * DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RSP  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      mem_q [DEPTH];
  logic [XLEN-1:0]      rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 cmd_hsk, rsp_hsk;
  logic [ADDR_SIZE-1:0] offset;
  logic                 in_range, aligned, acc_err;
  logic [IDX_W-1:0]     index;

  // Unsigned offset: an address below the base wraps to a huge value and fails the span test.
  assign offset   = icb_cmd_addr - BASE_ADDR;
  assign in_range = (icb_cmd_addr >= BASE_ADDR) && (offset < SPAN);
  assign aligned  = (icb_cmd_addr[1:0] == 2'b00);
  assign acc_err  = !in_range || !aligned;
  assign index    = offset[IDX_W+1:2];

  // rsp_hsk is formed from the state directly so cmd_ready has no path through rsp_valid.
  assign rsp_hsk = (state_q == S_RSP) && icb_rsp_ready;
  assign cmd_hsk = icb_cmd_valid && icb_cmd_ready;

  // State register; only control and response registers are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: a new command may refill RSP in the same cycle the old beat drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_hsk) state_d = S_RSP;
      S_RSP:   if (rsp_hsk && !cmd_hsk) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response beat capture: read data sees the word before any same-cycle store.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (cmd_hsk) begin
      err_d   = acc_err;
      rdata_d = (icb_cmd_read && !acc_err) ? mem_q[index] : '0;
    end
  end

  // Output decode from the current state.
  always_comb begin
    icb_rsp_valid = (state_q == S_RSP);
    busy          = (state_q == S_RSP);
    icb_cmd_ready = !rst && ((state_q == S_IDLE) || rsp_hsk);
  end

  // Byte-masked scratchpad write; erroring stores leave memory untouched.
  always_ff @(posedge clk) begin
    if (cmd_hsk && !icb_cmd_read && !acc_err) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (icb_cmd_wmask[i]) begin
          mem_q[index][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
        end
      end
    end
  end

  assign icb_rsp_rdata = rdata_q;
  assign icb_rsp_err   = err_q;

endmodule
